// File: rtl/disp_rdarb_pkg.sv
// Shared definitions for the display VRAM read arbiter: FSM state encodings,
// grant IDs and default sizing parameters.
package disp_rdarb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } ar_state_t;

    typedef enum logic {
        GNT_DISP = 1'b0,
        GNT_DRAW = 1'b1
    } gnt_t;

    localparam int DEF_OUTSTD     = 4;
    localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/disp_rdarb_ordfifo.sv
// Ordering FIFO for the read arbiter: remembers which requester owns each
// outstanding burst. One bit wide, DEPTH entries (power of two, >= 2).
module disp_rdarb_ordfifo #(
    parameter int DEPTH = 4
) (
    input  logic ACLK,
    input  logic ARST_N,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer MSB separates full from empty when the indices match.
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/disp_vram_rdarb.sv
// Two-requester AXI read arbiter onto the VRAM port; S0 (display) has priority.
// Optional feature: ARB_STARVE_LIMIT_EN bounds how long S1 can be starved.
module disp_vram_rdarb
    import disp_rdarb_pkg::*;
#(
    parameter int DW         = 64,
    parameter int OUTSTD     = DEF_OUTSTD,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          ACLK,
    input  logic          ARST_N,

    input  logic [31:0]   S0_ARADDR,
    input  logic          S0_ARVALID,
    output logic          S0_ARREADY,
    output logic [DW-1:0] S0_RDATA,
    output logic          S0_RVALID,
    output logic          S0_RLAST,
    input  logic          S0_RREADY,

    input  logic [31:0]   S1_ARADDR,
    input  logic          S1_ARVALID,
    output logic          S1_ARREADY,
    output logic [DW-1:0] S1_RDATA,
    output logic          S1_RVALID,
    output logic          S1_RLAST,
    input  logic          S1_RREADY,

    output logic [31:0]   M_ARADDR,
    output logic          M_ARVALID,
    input  logic          M_ARREADY,
    input  logic [DW-1:0] M_RDATA,
    input  logic          M_RVALID,
    input  logic          M_RLAST,
    output logic          M_RREADY
);

    ar_state_t state;
    gnt_t      gnt;
    gnt_t      next_gnt;
    logic      ar_req;
    logic      ar_hs;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_head;
    logic      r_pop;

    assign ar_req = S0_ARVALID | S1_ARVALID;
    assign ar_hs  = M_ARVALID & M_ARREADY;

`ifdef ARB_STARVE_LIMIT_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_cnt;
    logic           starve_hit;

    assign starve_hit = S1_ARVALID && (starve_cnt == SCW'(STARVE_MAX));

    // Counts S0 wins that S1 had to sit through; never passes STARVE_MAX
    // because reaching it forces the next decision to S1.
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE && !fifo_full && ar_req) begin
            if (next_gnt == GNT_DRAW) begin
                starve_cnt <= '0;
            end else if (S1_ARVALID) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        next_gnt = S0_ARVALID ? GNT_DISP : GNT_DRAW;
`ifdef ARB_STARVE_LIMIT_EN
        if (starve_hit) begin
            next_gnt = GNT_DRAW;
        end
`endif
    end

    // Grant is latched on IDLE exit and held through ADDR so a late S0
    // request cannot pull the address out from under a pending S1 grant.
    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= ST_IDLE;
            gnt   <= GNT_DISP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_full && ar_req) begin
                        gnt   <= next_gnt;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (M_ARREADY) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign M_ARVALID  = (state == ST_ADDR);
    assign M_ARADDR   = (gnt == GNT_DRAW) ? S1_ARADDR : S0_ARADDR;
    assign S0_ARREADY = M_ARVALID & (gnt == GNT_DISP) & M_ARREADY;
    assign S1_ARREADY = M_ARVALID & (gnt == GNT_DRAW) & M_ARREADY;

    disp_rdarb_ordfifo #(
        .DEPTH (OUTSTD)
    ) u_ordfifo (
        .ACLK   (ACLK),
        .ARST_N (ARST_N),
        .push   (ar_hs),
        .pop    (r_pop),
        .din    (gnt),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Beats with no recorded owner are stalled rather than dropped.
    assign M_RREADY  = !fifo_empty && (fifo_head ? S1_RREADY : S0_RREADY);
    assign S0_RVALID = M_RVALID && !fifo_empty && !fifo_head;
    assign S1_RVALID = M_RVALID && !fifo_empty && fifo_head;
    assign r_pop     = M_RVALID & M_RREADY & M_RLAST;

    assign S0_RDATA = M_RDATA;
    assign S1_RDATA = M_RDATA;
    assign S0_RLAST = M_RLAST;
    assign S1_RLAST = M_RLAST;

endmodule

// File: tb/tb_disp_vram_rdarb.sv
// Directed bench for disp_vram_rdarb: per-cycle vector table plus hand-written
// multi-cycle sequences for FIFO full, starvation limit and async reset.
module tb_disp_vram_rdarb;

    localparam int  DW = 64;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          ACLK;
    logic          ARST_N;
    logic [31:0]   s0_araddr, s1_araddr, m_araddr;
    logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [DW-1:0] s0_rdata, s1_rdata, m_rdata;
    logic          s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
    logic          s0_rready, s1_rready;
    logic          m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;

    int vec_count = 0;
    int err_count = 0;

    disp_vram_rdarb #(
        .DW         (DW),
        .OUTSTD     (4),
        .STARVE_MAX (2)
    ) dut (
        .ACLK       (ACLK),
        .ARST_N     (ARST_N),
        .S0_ARADDR  (s0_araddr),
        .S0_ARVALID (s0_arvalid),
        .S0_ARREADY (s0_arready),
        .S0_RDATA   (s0_rdata),
        .S0_RVALID  (s0_rvalid),
        .S0_RLAST   (s0_rlast),
        .S0_RREADY  (s0_rready),
        .S1_ARADDR  (s1_araddr),
        .S1_ARVALID (s1_arvalid),
        .S1_ARREADY (s1_arready),
        .S1_RDATA   (s1_rdata),
        .S1_RVALID  (s1_rvalid),
        .S1_RLAST   (s1_rlast),
        .S1_RREADY  (s1_rready),
        .M_ARADDR   (m_araddr),
        .M_ARVALID  (m_arvalid),
        .M_ARREADY  (m_arready),
        .M_RDATA    (m_rdata),
        .M_RVALID   (m_rvalid),
        .M_RLAST    (m_rlast),
        .M_RREADY   (m_rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Each record is one clock cycle: inputs applied after the falling edge,
    // outputs checked before the following rising edge.
    typedef struct {
        logic          s0v;
        logic [31:0]   s0a;
        logic          s1v;
        logic [31:0]   s1a;
        logic          arrdy;
        logic          rv;
        logic          rl;
        logic [DW-1:0] rd;
        logic          s0rr;
        logic          s1rr;
        logic          e_marv;
        logic [31:0]   e_maddr;
        logic          e_s0ar;
        logic          e_s1ar;
        logic          e_s0rv;
        logic          e_s1rv;
        logic          e_mrr;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s0_arvalid = v.s0v;
        s0_araddr  = v.s0a;
        s1_arvalid = v.s1v;
        s1_araddr  = v.s1a;
        m_arready  = v.arrdy;
        m_rvalid   = v.rv;
        m_rlast    = v.rl;
        m_rdata    = v.rd;
        s0_rready  = v.s0rr;
        s1_rready  = v.s1rr;
    endtask

    task automatic idleInputs();
        s0_arvalid = 1'b0;
        s0_araddr  = '0;
        s1_arvalid = 1'b0;
        s1_araddr  = '0;
        m_arready  = 1'b1;
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        m_rdata    = '0;
        s0_rready  = 1'b1;
        s1_rready  = 1'b1;
    endtask

    task automatic resetDut();
        @(negedge ACLK);
        ARST_N = 1'b0;
        idleInputs();
        repeat (2) @(negedge ACLK);
        ARST_N = 1'b1;
    endtask

    logic [39:0] act_row, exp_row;
    logic        data_ok;
    logic [31:0] t1_addr[3];
    logic        got;
    int          hs;
    int          n_gnt;
    logic        grants[6];
    logic        exp_grants[6];

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // cols: s0v,s0a,s1v,s1a,arrdy,rv,rl,rd,s0rr,s1rr | marv,maddr,s0ar,s1ar,s0rv,s1rv,mrr
        vecs[0]  = '{H,32'h1000,H,32'h2000,H,L,L,64'h0,H,H, L,32'h0,   L,L,L,L,L};
        vecs[1]  = '{H,32'h1000,H,32'h2000,H,L,L,64'h0,H,H, H,32'h1000,H,L,L,L,L};
        vecs[2]  = '{L,32'h0,   H,32'h2000,H,L,L,64'h0,H,H, L,32'h0,   L,L,L,L,H};
        vecs[3]  = '{L,32'h0,   H,32'h2000,H,L,L,64'h0,H,H, H,32'h2000,L,H,L,L,H};
        vecs[4]  = '{L,32'h0,   L,32'h0,   H,H,L,64'hA1,H,H, L,32'h0,  L,L,H,L,H};
        vecs[5]  = '{L,32'h0,   L,32'h0,   H,H,H,64'hA2,H,H, L,32'h0,  L,L,H,L,H};
        vecs[6]  = '{L,32'h0,   L,32'h0,   H,H,L,64'hB1,H,H, L,32'h0,  L,L,L,H,H};
        vecs[7]  = '{L,32'h0,   L,32'h0,   H,H,L,64'hB2,H,L, L,32'h0,  L,L,L,H,L};
        vecs[8]  = '{L,32'h0,   L,32'h0,   H,H,H,64'hB2,H,H, L,32'h0,  L,L,L,H,H};
        vecs[9]  = '{L,32'h0,   L,32'h0,   H,H,H,64'hC0,H,H, L,32'h0,  L,L,L,L,L};
        vecs[10] = '{H,32'h3000,L,32'h0,   H,L,L,64'h0,H,H, L,32'h0,   L,L,L,L,L};
        vecs[11] = '{H,32'h3000,L,32'h0,   H,L,L,64'h0,H,H, H,32'h3000,H,L,L,L,L};
        vecs[12] = '{H,32'h3100,L,32'h0,   H,H,L,64'hD1,H,H, L,32'h0,  L,L,H,L,H};
        vecs[13] = '{H,32'h3100,L,32'h0,   H,H,H,64'hD2,H,H, H,32'h3100,H,L,H,L,H};
        vecs[14] = '{L,32'h0,   L,32'h0,   H,H,H,64'hE1,H,H, L,32'h0,  L,L,H,L,H};
        vecs[15] = '{L,32'h0,   L,32'h0,   H,H,H,64'hE2,H,H, L,32'h0,  L,L,L,L,L};
        vecs[16] = '{L,32'h0,   L,32'h0,   H,L,L,64'h0,H,H, L,32'h0,   L,L,L,L,L};

        t1_addr[0] = 32'h1000;
        t1_addr[1] = 32'h1100;
        t1_addr[2] = 32'h1200;

`ifdef ARB_STARVE_LIMIT_EN
        exp_grants[0] = 1'b0; exp_grants[1] = 1'b0; exp_grants[2] = 1'b1;
        exp_grants[3] = 1'b0; exp_grants[4] = 1'b0; exp_grants[5] = 1'b1;
`else
        for (int i = 0; i < 6; i++) exp_grants[i] = 1'b0;
`endif

        ARST_N = 1'b0;
        idleInputs();
        m_rvalid = 1'b1;
        #2;
        checkOutput("reset_state",
                    {m_arvalid, s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_rready},
                    96'h0);
        resetDut();

        // Table: simultaneous requests, in-order routing, backpressure, push/pop overlap.
        for (int i = 0; i < 17; i++) begin
            @(negedge ACLK);
            applyStimulus(vecs[i]);
            #1;
            data_ok = (s0_rdata === m_rdata) && (s1_rdata === m_rdata) &&
                      (s0_rlast === m_rlast) && (s1_rlast === m_rlast);
            act_row = {m_arvalid, s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_rready,
                       (vecs[i].e_marv ? m_araddr : 32'h0), data_ok};
            exp_row = {vecs[i].e_marv, vecs[i].e_s0ar, vecs[i].e_s1ar, vecs[i].e_s0rv,
                       vecs[i].e_s1rv, vecs[i].e_mrr,
                       (vecs[i].e_marv ? vecs[i].e_maddr : 32'h0), 1'b1};
            checkOutput($sformatf("vec%0d", i), {56'h0, act_row}, {56'h0, exp_row});
        end

        // S0 only: three ARs then 3x8 beats, all routed to S0.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            s0_arvalid = 1'b1;
            s0_araddr  = t1_addr[i];
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                #1;
                if (m_arvalid && m_arready) begin
                    checkOutput($sformatf("t1_araddr%0d", i), {64'h0, m_araddr}, {64'h0, t1_addr[i]});
                    checkOutput($sformatf("t1_arready%0d", i), {95'h0, s0_arready}, 96'h1);
                    got = 1'b1;
                end else begin
                    @(negedge ACLK);
                end
            end
            if (!got) checkOutput("t1_ar_timeout", 96'h0, 96'h1);
        end
        @(negedge ACLK);
        s0_arvalid = 1'b0;
        for (int b = 0; b < 24; b++) begin
            @(negedge ACLK);
            m_rvalid = 1'b1;
            m_rlast  = ((b % 8) == 7);
            m_rdata  = 64'hD000 + 64'(b);
            #1;
            checkOutput($sformatf("t1_beat%0d", b),
                        {29'h0, s0_rvalid, s1_rvalid, m_rready, s0_rdata},
                        {29'h0, 1'b1, 1'b0, 1'b1, 64'hD000 + 64'(b)});
        end
        @(negedge ACLK);
        #1;
        checkOutput("t1_stray", {94'h0, s0_rvalid, m_rready}, 96'h0);
        m_rvalid = 1'b0;

        // FIFO full: 4 ARs accepted, 5th waits for the first RLAST pop.
        resetDut();
        hs = 0;
        @(negedge ACLK);
        s0_arvalid = 1'b1;
        s0_araddr  = 32'h4000;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_arvalid && m_arready) hs++;
            @(negedge ACLK);
        end
        #1;
        checkOutput("t3_hs_full", 96'(hs), 96'd4);
        checkOutput("t3_stalled", {95'h0, m_arvalid}, 96'h0);
        @(negedge ACLK);
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        #1;
        checkOutput("t3_pop_rready", {95'h0, m_rready}, 96'h1);
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ACLK);
            m_rvalid = 1'b0;
            #1;
            if (m_arvalid && m_arready) hs++;
        end
        checkOutput("t3_hs_fifth", 96'(hs), 96'd1);
        @(negedge ACLK);
        s0_arvalid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge ACLK);
            m_rvalid = 1'b1;
            m_rlast  = 1'b1;
            #1;
            checkOutput($sformatf("t3_drain%0d", p), {94'h0, s0_rvalid, m_rready}, 96'h3);
        end
        @(negedge ACLK);
        #1;
        checkOutput("t3_drained", {94'h0, s0_rvalid, m_rready}, 96'h0);
        m_rvalid = 1'b0;

        // Both requesters continuously valid; beats drained as fast as they come.
        resetDut();
        @(negedge ACLK);
        s0_arvalid = 1'b1;
        s0_araddr  = 32'h7000;
        s1_arvalid = 1'b1;
        s1_araddr  = 32'h8000;
        m_rvalid   = 1'b1;
        m_rlast    = 1'b1;
        n_gnt = 0;
        for (int c = 0; c < 60 && n_gnt < 6; c++) begin
            #1;
            if (m_arvalid && m_arready) begin
                grants[n_gnt] = s1_arready;
                n_gnt++;
            end
            @(negedge ACLK);
        end
        if (n_gnt < 6) checkOutput("t5_timeout", 96'(n_gnt), 96'd6);
        for (int i = 0; i < 6 && i < n_gnt; i++) begin
            checkOutput($sformatf("t5_grant%0d", i), {95'h0, grants[i]}, {95'h0, exp_grants[i]});
        end
        idleInputs();

        // Async reset while in ADDR with two bursts outstanding.
        resetDut();
        hs = 0;
        @(negedge ACLK);
        s0_arvalid = 1'b1;
        s0_araddr  = 32'h5000;
        for (int c = 0; c < 12 && hs < 2; c++) begin
            #1;
            if (m_arvalid && m_arready) hs++;
            @(negedge ACLK);
        end
        checkOutput("t6_prefill", 96'(hs), 96'd2);
        m_arready = 1'b0;
        @(negedge ACLK);
        #1;
        checkOutput("t6_in_addr", {95'h0, m_arvalid}, 96'h1);
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        #1;
        checkOutput("t6_pre_reset", {93'h0, s0_arready, s0_rvalid, m_rready}, 96'h7);
        ARST_N = 1'b0;
        #1;
        checkOutput("t6_async_clear",
                    {90'h0, m_arvalid, s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_rready},
                    96'h0);
        @(negedge ACLK);
        ARST_N     = 1'b1;
        idleInputs();
        s1_arvalid = 1'b1;
        s1_araddr  = 32'h6000;
        #1;
        checkOutput("t6_idle_after", {95'h0, m_arvalid}, 96'h0);
        @(negedge ACLK);
        #1;
        checkOutput("t6_s1_grant", {62'h0, m_arvalid, s1_arready, m_araddr}, {62'h0, 1'b1, 1'b1, 32'h6000});
        @(negedge ACLK);
        idleInputs();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
